// File: rtl/pad_acc_scheduler.sv
// Round-robin shared pad-and-accumulate path for NUM_CH sample requesters with framed output.
// Optional: define SPGD_PAD_SIGN_EXT_EN to sign-extend samples into the left pad.
module pad_acc_scheduler #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned IN_WIDTH    = 12,
    parameter int unsigned OUT_WIDTH   = 48,
    parameter int unsigned L_PAD_WIDTH = 4,
    parameter int unsigned R_PAD_WIDTH = 32,
    parameter int unsigned FRAME_LEN   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        clear,
    input  logic [NUM_CH-1:0]           req_valid,
    input  logic [NUM_CH*IN_WIDTH-1:0]  req_data,
    output logic [NUM_CH-1:0]           req_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OUT_WIDTH-1:0]        out_data,
    output logic [$clog2(NUM_CH)-1:0]   out_ch
);

    localparam int unsigned ChW  = $clog2(NUM_CH);
    localparam int unsigned CntW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(FRAME_LEN - 1);
    localparam logic [ChW-1:0]  ChLast  = ChW'(NUM_CH - 1);
    localparam logic [ChW:0]    ChCount = (ChW + 1)'(NUM_CH);

    if (L_PAD_WIDTH + IN_WIDTH + R_PAD_WIDTH != OUT_WIDTH) begin : g_bad_width
        $error("pad_acc_scheduler: L_PAD_WIDTH + IN_WIDTH + R_PAD_WIDTH must equal OUT_WIDTH");
    end
    if (NUM_CH < 2 || NUM_CH > 16) begin : g_bad_num_ch
        $error("pad_acc_scheduler: NUM_CH must be in 2..16");
    end
    if (FRAME_LEN < 1) begin : g_bad_frame_len
        $error("pad_acc_scheduler: FRAME_LEN must be at least 1");
    end

    logic [OUT_WIDTH-1:0] acc_q [NUM_CH];
    logic [OUT_WIDTH-1:0] acc_d [NUM_CH];
    logic [CntW-1:0]      cnt_q [NUM_CH];
    logic [CntW-1:0]      cnt_d [NUM_CH];
    logic [ChW-1:0]       rr_q, rr_d;
    logic                 out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic [ChW-1:0]       out_ch_q, out_ch_d;

    logic [IN_WIDTH-1:0]  sample_arr [NUM_CH];
    logic [NUM_CH-1:0]    eligible;
    logic [NUM_CH-1:0]    grant;
    logic [ChW-1:0]       gidx;
    logic                 hs;
    logic                 out_busy;
    logic [IN_WIDTH-1:0]  sample;
    logic [OUT_WIDTH-1:0] pad;
    logic [OUT_WIDTH-1:0] sum;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign sample_arr[i] = req_data[i*IN_WIDTH +: IN_WIDTH];
    end

    assign out_busy = out_valid_q & ~out_ready;

    // A frame-completing sample is held back only while the output cannot take it.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            eligible[i] = req_valid[i] & en & ~clear & ~rst
                        & ~((cnt_q[i] == CntLast) & out_busy);
        end
    end

    always_comb begin
        logic [ChW:0]   slot;
        logic [ChW-1:0] idx;
        grant = '0;
        gidx  = '0;
        hs    = 1'b0;
        slot  = '0;
        idx   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            slot = {1'b0, rr_q} + (ChW + 1)'(k);
            if (slot >= ChCount) begin
                slot = slot - ChCount;
            end
            idx = slot[ChW-1:0];
            if (!hs && eligible[idx]) begin
                grant[idx] = 1'b1;
                gidx       = idx;
                hs         = 1'b1;
            end
        end
    end

    assign sample = sample_arr[gidx];

`ifdef SPGD_PAD_SIGN_EXT_EN
    assign pad = {{L_PAD_WIDTH{sample[IN_WIDTH-1]}}, sample, {R_PAD_WIDTH{1'b0}}};
`else
    assign pad = {{L_PAD_WIDTH{1'b0}}, sample, {R_PAD_WIDTH{1'b0}}};
`endif

    assign sum = acc_q[gidx] + pad;

    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        rr_d        = rr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (clear) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_d[i] = '0;
                cnt_d[i] = '0;
            end
        end else if (hs) begin
            rr_d = (gidx == ChLast) ? '0 : gidx + 1'b1;
            if (cnt_q[gidx] == CntLast) begin
                // A completing frame overrides the drain of the previous result.
                acc_d[gidx] = '0;
                cnt_d[gidx] = '0;
                out_valid_d = 1'b1;
                out_data_d  = sum;
                out_ch_d    = gidx;
            end else begin
                acc_d[gidx] = sum;
                cnt_d[gidx] = cnt_q[gidx] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= '0;
                cnt_q[i] <= '0;
            end
            rr_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= acc_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            rr_q        <= rr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign req_ready = grant;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_pad_acc_scheduler.sv
// Randomized bench for pad_acc_scheduler against a per-cycle behavioural model of channel sums.
module tb_pad_acc_scheduler;

    localparam int unsigned NCH = 4;
    localparam int unsigned IW  = 12;
    localparam int unsigned OW  = 48;
    localparam int unsigned LW  = 4;
    localparam int unsigned RW  = 32;
    localparam int unsigned FL  = 4;
    localparam longint unsigned Mask = (64'd1 << OW) - 64'd1;

    logic              clk = 1'b0;
    logic              rst, en, clear, out_ready, out_valid;
    logic [NCH-1:0]    req_valid, req_ready;
    logic [NCH*IW-1:0] req_data;
    logic [OW-1:0]     out_data;
    logic [1:0]        out_ch;

    always #5 clk = ~clk;

    pad_acc_scheduler #(
        .NUM_CH      (NCH),
        .IN_WIDTH    (IW),
        .OUT_WIDTH   (OW),
        .L_PAD_WIDTH (LW),
        .R_PAD_WIDTH (RW),
        .FRAME_LEN   (FL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .clear     (clear),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: channel running sums, sample counts, next-priority channel, held result.
    longint unsigned m_acc [NCH];
    int              m_cnt [NCH];
    int              m_rr;
    bit              m_ov;
    longint unsigned m_od;
    int              m_och;

    function automatic longint unsigned pad_of(input logic [IW-1:0] s);
        longint unsigned p;
        p = longint'(s) << RW;
`ifdef SPGD_PAD_SIGN_EXT_EN
        if (s[IW-1]) p = p | (((64'd1 << LW) - 64'd1) << (IW + RW));
`endif
        return p & Mask;
    endfunction

    function automatic logic [NCH*IW-1:0] one_ch(input int ch, input logic [IW-1:0] val);
        logic [NCH*IW-1:0] d;
        d = '0;
        d[ch*IW +: IW] = val;
        return d;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_acc[i] = 0;
            m_cnt[i] = 0;
        end
        m_rr = 0; m_ov = 0; m_od = 0; m_och = 0;
    endtask

    task automatic cycle(input bit r, input bit e, input bit c, input logic [NCH-1:0] v,
                         input logic [NCH*IW-1:0] d, input bit ordy);
        int              g;
        bit              busy;
        bit              done;
        logic [NCH-1:0]  exp_rdy;
        longint unsigned s;
        rst = r; en = e; clear = c; req_valid = v; req_data = d; out_ready = ordy;
        #1;
        g = -1;
        exp_rdy = '0;
        busy = m_ov && !ordy;
        if (!r) begin
            for (int k = 0; k < NCH; k++) begin
                int i;
                i = (m_rr + k) % NCH;
                if (g < 0 && v[i] && e && !c && !(m_cnt[i] == FL - 1 && busy)) g = i;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        @(posedge clk);
        #1;
        if (r) begin
            model_reset();
        end else begin
            done = 0;
            if (c) begin
                for (int i = 0; i < NCH; i++) begin
                    m_acc[i] = 0;
                    m_cnt[i] = 0;
                end
            end
            if (g >= 0) begin
                s = (m_acc[g] + pad_of(d[g*IW +: IW])) & Mask;
                m_rr = (g + 1) % NCH;
                if (m_cnt[g] == FL - 1) begin
                    m_acc[g] = 0;
                    m_cnt[g] = 0;
                    m_od = s;
                    m_och = g;
                    done = 1;
                end else begin
                    m_acc[g] = s;
                    m_cnt[g]++;
                end
            end
            if (done) m_ov = 1;
            else if (m_ov && ordy) m_ov = 0;
        end
        check("out_valid", 64'(out_valid), 64'(m_ov));
        check("out_data", 64'(out_data), m_od);
        check("out_ch", 64'(out_ch), 64'(m_och));
    endtask

    initial begin
        int pct;
        logic [63:0] sign_exp;
        model_reset();

        repeat (2) cycle(1, 1, 0, '1, '0, 1'b0);

        // Pad and accumulate on ch0, then a second frame from zero.
        repeat (4) cycle(0, 1, 0, 4'b0001, one_ch(0, 12'h001), 1'b1);
        check("pad_frame_valid", 64'(out_valid), 64'd1);
        check("pad_frame_data", 64'(out_data), 64'h0004_0000_0000);
        check("pad_frame_ch", 64'(out_ch), 64'd0);
        repeat (4) cycle(0, 1, 0, 4'b0001, one_ch(0, 12'h001), 1'b1);

        // Round robin with all requesting, then ch2 dropped.
        repeat (8) cycle(0, 1, 0, 4'b1111, {4{12'h010}}, 1'b1);
        repeat (6) cycle(0, 1, 0, 4'b1011, {4{12'h010}}, 1'b1);

        // Clear mid-frame on ch1.
        cycle(1, 0, 0, '0, '0, 1'b1);
        repeat (3) cycle(0, 1, 0, 4'b0010, one_ch(1, 12'h002), 1'b1);
        cycle(0, 1, 1, 4'b0010, one_ch(1, 12'h002), 1'b1);
        repeat (4) cycle(0, 1, 0, 4'b0010, one_ch(1, 12'h002), 1'b1);
        check("clear_frame_data", 64'(out_data), 64'h0008_0000_0000);
        check("clear_frame_ch", 64'(out_ch), 64'd1);

        // Reset mid-frame with a pending result.
        repeat (2) cycle(0, 1, 0, 4'b0010, one_ch(1, 12'h002), 1'b0);
        cycle(1, 1, 0, 4'b0010, one_ch(1, 12'h002), 1'b0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);

        // Sign handling of the left pad.
        repeat (4) cycle(0, 1, 0, 4'b0001, one_ch(0, 12'h800), 1'b1);
`ifdef SPGD_PAD_SIGN_EXT_EN
        sign_exp = 64'h0000_E000_0000_0000;
`else
        sign_exp = 64'h0000_2000_0000_0000;
`endif
        check("sign_frame_data", 64'(out_data), sign_exp);

        // Randomized traffic, with phases of heavy and light backpressure.
        for (int n = 0; n < 3000; n++) begin
            pct = ((n / 500) % 2 == 0) ? 70 : 20;
            cycle($urandom_range(0, 199) == 0,
                  $urandom_range(0, 9) != 0,
                  $urandom_range(0, 39) == 0,
                  NCH'($urandom),
                  {$urandom, $urandom},
                  $urandom_range(0, 99) < pct);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
